// File: rtl/bus_register_bank.sv
// bus_register_bank: NREG x WIDTH register bank with per-register load/shift/inc/dec/clear,
// a registered carry flag and one tri-state read port onto the bus.
module bus_register_bank #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int SELW  = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    output tri   [WIDTH-1:0] Q,
    input  logic [2:0]       OP,
    input  logic [SELW-1:0]  WSEL,
    input  logic [SELW-1:0]  RSEL,
    input  logic [1:0]       G_bar,
    input  logic             M,
    input  logic             N,
    input  logic             SIN,
    output logic             CO,
    output logic             ZERO
);
    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101,
        OP_CLRR = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             co_q, co_d;
    logic [WIDTH-1:0] cur, nxt, rd;
    logic             co_n, wr, hit;

    always_comb begin
        regs_d = regs_q;
        co_d   = co_q;
        cur    = '0;
        hit    = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (WSEL == SELW'(i)) begin
                cur = regs_q[i];
                hit = 1'b1;
            end
        end
        nxt  = cur;
        co_n = 1'b0;
        wr   = 1'b1;
        case (op_e'(OP))
            OP_LOAD: nxt = D;
            OP_SHL:  {co_n, nxt} = {cur, SIN};
            OP_SHR:  {nxt, co_n} = {SIN, cur};
            OP_INC:  {co_n, nxt} = {1'b0, cur} + 1'b1;
            OP_DEC:  {co_n, nxt} = {1'b0, cur} - 1'b1;
            OP_CLRR: nxt = '0;
            default: wr = 1'b0;
        endcase
        // Out-of-range WSEL never matches a register, so hit also drops the CO update
        if (G_bar == 2'b00 && wr && hit) begin
            co_d = co_n;
            for (int i = 0; i < NREG; i++)
                if (WSEL == SELW'(i)) regs_d[i] = nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            co_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            co_q   <= co_d;
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NREG; i++)
            if (RSEL == SELW'(i)) rd = regs_q[i];
    end

    assign Q    = (M | N) ? 'z : rd;
    assign ZERO = (rd == '0);
    assign CO   = co_q;
endmodule

// File: tb/tb_bus_register_bank.sv
// tb_bus_register_bank: table-driven scoreboard bench for bus_register_bank (WIDTH=8, NREG=3).
// A disabled bus is seen as all ones through weak pull-ups on Q.
module tb_bus_register_bank;
    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                           INC = 3'b100, DEC = 3'b101, CLRR = 3'b110, RSVD = 3'b111;
    localparam logic [7:0] BUSZ = 8'hFF;

    logic       CLK = 1'b0;
    logic       CLR, M, N, SIN;
    logic [7:0] D;
    logic [2:0] OP;
    logic [1:0] WSEL, RSEL, G_bar;
    logic       CO, ZERO;
    wire  [7:0] Q;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (Q[g]);
    end

    bus_register_bank #(.WIDTH(8), .NREG(3), .SELW(2)) dut (
        .CLK(CLK), .CLR(CLR), .D(D), .Q(Q), .OP(OP), .WSEL(WSEL), .RSEL(RSEL),
        .G_bar(G_bar), .M(M), .N(N), .SIN(SIN), .CO(CO), .ZERO(ZERO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       clr;
        logic [1:0] gb;
        logic [2:0] op;
        logic [1:0] ws, rs;
        logic [7:0] d;
        logic       sin, m, n;
        logic [7:0] eq;
        logic       eco, ez;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(string name, logic clr, logic [1:0] gb, logic [2:0] op,
                                logic [1:0] ws, logic [1:0] rs, logic [7:0] d, logic sin,
                                logic m, logic n, logic [7:0] eq, logic eco, logic ez);
        vec_t v;
        v.name = name; v.clr = clr; v.gb = gb; v.op = op; v.ws = ws; v.rs = rs;
        v.d = d; v.sin = sin; v.m = m; v.n = n; v.eq = eq; v.eco = eco; v.ez = ez;
        return v;
    endfunction

    task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        CLR = v.clr; G_bar = v.gb; OP = v.op; WSEL = v.ws; RSEL = v.rs;
        D = v.d; SIN = v.sin; M = v.m; N = v.n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        //               name         clr  gb     op    ws rs d      sin m  n  Q      CO ZERO
        vecs.push_back(mk("rst",       1, 2'b00, INC,  0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk("rst_r1",    0, 2'b00, HOLD, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk("rst_r2",    0, 2'b00, HOLD, 0, 2, 8'h00, 0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk("ld_ff",     0, 2'b00, LOAD, 1, 1, 8'hFF, 0, 0, 0, 8'hFF, 0, 0));
        vecs.push_back(mk("inc_wrap",  0, 2'b00, INC,  1, 1, 8'h00, 0, 0, 0, 8'h00, 1, 1));
        vecs.push_back(mk("dec_wrap",  0, 2'b00, DEC,  1, 1, 8'h00, 0, 0, 0, 8'hFF, 1, 0));
        vecs.push_back(mk("dec",       0, 2'b00, DEC,  1, 1, 8'h00, 0, 0, 0, 8'hFE, 0, 0));
        vecs.push_back(mk("ld_81",     0, 2'b00, LOAD, 0, 0, 8'h81, 0, 0, 0, 8'h81, 0, 0));
        vecs.push_back(mk("shl",       0, 2'b00, SHL,  0, 0, 8'h00, 0, 0, 0, 8'h02, 1, 0));
        vecs.push_back(mk("shr",       0, 2'b00, SHR,  0, 0, 8'h00, 1, 0, 0, 8'h81, 0, 0));
        vecs.push_back(mk("gate01",    0, 2'b01, LOAD, 0, 0, 8'h55, 0, 0, 0, 8'h81, 0, 0));
        vecs.push_back(mk("gate10",    0, 2'b10, LOAD, 0, 0, 8'h55, 0, 0, 0, 8'h81, 0, 0));
        vecs.push_back(mk("m_dis",     0, 2'b00, HOLD, 0, 0, 8'h00, 0, 1, 0, BUSZ,  0, 0));
        vecs.push_back(mk("m_ld",      0, 2'b00, LOAD, 0, 0, 8'h3C, 0, 1, 0, BUSZ,  0, 0));
        vecs.push_back(mk("n_inc",     0, 2'b00, INC,  0, 0, 8'h00, 0, 0, 1, BUSZ,  0, 0));
        vecs.push_back(mk("reenable",  0, 2'b00, HOLD, 0, 0, 8'h00, 0, 0, 0, 8'h3D, 0, 0));
        vecs.push_back(mk("dec_r2",    0, 2'b00, DEC,  2, 2, 8'h00, 0, 0, 0, 8'hFF, 1, 0));
        vecs.push_back(mk("ws_oor",    0, 2'b00, LOAD, 3, 0, 8'hAA, 0, 0, 0, 8'h3D, 1, 0));
        vecs.push_back(mk("rs_oor",    0, 2'b00, HOLD, 0, 3, 8'h00, 0, 0, 0, 8'h00, 1, 1));
        vecs.push_back(mk("r1_keep",   0, 2'b00, HOLD, 0, 1, 8'h00, 0, 0, 0, 8'hFE, 1, 0));
        vecs.push_back(mk("rsvd",      0, 2'b00, RSVD, 1, 1, 8'h12, 0, 0, 0, 8'hFE, 1, 0));
        vecs.push_back(mk("clrr",      0, 2'b00, CLRR, 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk("ld_10",     0, 2'b00, LOAD, 2, 2, 8'h10, 0, 0, 0, 8'h10, 0, 0));
        vecs.push_back(mk("inc_r2",    0, 2'b00, INC,  2, 2, 8'h00, 0, 0, 0, 8'h11, 0, 0));
        vecs.push_back(mk("clr_inc",   1, 2'b00, INC,  2, 2, 8'h00, 0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk("clr_r0",    0, 2'b00, HOLD, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1));

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            chk8({e.name, "_q"}, Q, e.eq);
            chk1({e.name, "_co"}, CO, e.eco);
            chk1({e.name, "_zero"}, ZERO, e.ez);
        end

        // No write-to-read bypass: old value visible until the edge
        @(negedge CLK);
        CLR = 0; G_bar = 2'b00; OP = LOAD; WSEL = 1; RSEL = 1; D = 8'h77; M = 0; N = 0;
        #1;
        chk8("nobypass_pre_q", Q, 8'h00);
        chk1("nobypass_pre_zero", ZERO, 1'b1);
        @(posedge CLK);
        #1;
        chk8("nobypass_post_q", Q, 8'h77);
        chk1("nobypass_post_zero", ZERO, 1'b0);

        // Read select is combinational; ZERO ignores M
        @(negedge CLK);
        OP = HOLD; RSEL = 0;
        #1;
        chk8("rsel_comb_q", Q, 8'h00);
        M = 1; RSEL = 1;
        #1;
        chk8("dis_comb_q", Q, BUSZ);
        chk1("dis_comb_zero", ZERO, 1'b0);

        // Reset aborts a shift sequence
        @(negedge CLK);
        M = 0; OP = SHL; WSEL = 1; SIN = 1;
        @(posedge CLK);
        #1;
        chk8("seq_shl_q", Q, 8'hEF);
        chk1("seq_shl_co", CO, 1'b0);
        @(negedge CLK);
        CLR = 1;
        @(posedge CLK);
        #1;
        chk8("seq_abort_q", Q, 8'h00);
        chk1("seq_abort_co", CO, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
